// File: rtl/fma_pkg.sv
// ============================================================================
// Module : fma_pkg
// Brief  : Shared constants and types for the FMA operand/result steering.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fma_pkg;

  localparam int   DATA_W   = 8;
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/out_slot.sv
// ============================================================================
// Module : out_slot
// Brief  : One-entry output register slot with valid/ready handshake.
//          Transfer counter present only when DEMUX_CNT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module out_slot
  import fma_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_t      r_state;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign w_drain = (r_state == ST_FULL) & ready;
  assign valid   = (r_state == ST_FULL);
  assign data    = r_data;

  // A load always wins: it fills an empty slot or replaces a draining beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
    end else if (load) begin
      r_state <= ST_FULL;
      r_data  <= din;
    end else if (w_drain) begin
      r_state <= ST_EMPTY;
    end
  end

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("out_slot: CNT_W must be at least 1");
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
`endif

endmodule

`default_nettype wire

// File: rtl/demux_1_2_slot.sv
// ============================================================================
// Module : demux_1_2_slot
// Brief  : Steers one result stream to one of two slotted destinations.
//          Optional per-output transfer counters: DEMUX_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_1_2_slot
  import fma_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] out0_cnt,
  output logic [CNT_W-1:0] out1_cnt
`endif
);

  logic w_sel_valid;
  logic w_sel_ready;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // Ready depends on the selected slot only, so the other slot drains freely.
  assign w_sel_valid = (in_sel == SEL_OUT1) ? out1_valid : out0_valid;
  assign w_sel_ready = (in_sel == SEL_OUT1) ? out1_ready : out0_ready;
  assign in_ready    = ~rst & (~w_sel_valid | w_sel_ready);
  assign w_accept    = in_valid & in_ready;
  assign w_load0     = w_accept & (in_sel == SEL_OUT0);
  assign w_load1     = w_accept & (in_sel == SEL_OUT1);

  out_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot0 (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load0),
    .din   (in_data),
    .ready (out0_ready),
    .valid (out0_valid),
    .data  (out0_data)
`ifdef DEMUX_CNT_EN
    ,
    .cnt   (out0_cnt)
`endif
  );

  out_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load1),
    .din   (in_data),
    .ready (out1_ready),
    .valid (out1_valid),
    .data  (out1_data)
`ifdef DEMUX_CNT_EN
    ,
    .cnt   (out1_cnt)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_demux_1_2_slot.sv
// ============================================================================
// Module : tb_demux_1_2_slot
// Brief  : Self-checking bench for demux_1_2_slot (directed vectors + model).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_1_2_slot;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sel = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out0_valid, out1_valid;
  logic       out0_ready = 1'b0;
  logic       out1_ready = 1'b0;
  logic [7:0] out0_data, out1_data;
`ifdef DEMUX_CNT_EN
  logic [15:0] out0_cnt, out1_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_1_2_slot dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
    ,
    .out0_cnt   (out0_cnt),
    .out1_cnt   (out1_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each destination is a holding place for at most one beat.
  bit          m_full [2] = '{0, 0};
  logic [7:0]  m_data [2] = '{8'h00, 8'h00};
  int unsigned m_cnt  [2] = '{0, 0};

  function automatic bit rdy_of(input int k);
    return (k == 0) ? out0_ready : out1_ready;
  endfunction

  always @(posedge clk) begin
    bit acc;
    int s;
    s = int'(in_sel);
    if (rst) begin
      m_full = '{0, 0};
      m_cnt  = '{0, 0};
    end else begin
      acc = in_valid && (!m_full[s] || rdy_of(s));
      for (int k = 0; k < 2; k++) begin
        if (m_full[k] && rdy_of(k)) begin
          m_full[k] = 0;
          m_cnt[k]  = (m_cnt[k] + 1) % 65536;
        end
      end
      if (acc) begin
        m_full[s] = 1;
        m_data[s] = in_data;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready_model", {31'd0, in_ready},
        {31'd0, !rst && (!m_full[int'(in_sel)] || rdy_of(int'(in_sel)))});
    chk("out0_valid_model", {31'd0, out0_valid}, {31'd0, m_full[0]});
    chk("out1_valid_model", {31'd0, out1_valid}, {31'd0, m_full[1]});
    if (m_full[0]) chk("out0_data_model", {24'd0, out0_data}, {24'd0, m_data[0]});
    if (m_full[1]) chk("out1_data_model", {24'd0, out1_data}, {24'd0, m_data[1]});
`ifdef DEMUX_CNT_EN
    chk("out0_cnt_model", {16'd0, out0_cnt}, m_cnt[0]);
    chk("out1_cnt_model", {16'd0, out1_cnt}, m_cnt[1]);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with a valid beat offered
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h99;
    out0_ready = 1'b1; out1_ready = 1'b1;
    cyc(); cyc();
    chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("rst_out0_data", {24'd0, out0_data}, 32'h00);
    chk("rst_out1_data", {24'd0, out1_data}, 32'h00);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef DEMUX_CNT_EN
    chk("rst_out0_cnt", {16'd0, out0_cnt}, 32'd0);
    chk("rst_out1_cnt", {16'd0, out1_cnt}, 32'd0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    cyc();

    // Basic route
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h3C;
    #1 chk("route_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("route_out0_valid", {31'd0, out0_valid}, 32'd1);
    chk("route_out0_data", {24'd0, out0_data}, 32'h3C);
    in_sel = 1'b1; in_data = 8'hA5;
    cyc();
    chk("route_out0_done", {31'd0, out0_valid}, 32'd0);
    chk("route_out1_valid", {31'd0, out1_valid}, 32'd1);
    chk("route_out1_data", {24'd0, out1_data}, 32'hA5);
    in_valid = 1'b0;
    cyc();
    chk("route_out1_done", {31'd0, out1_valid}, 32'd0);

    // Stall isolation
    out0_ready = 1'b0; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
    cyc();
    chk("stall_out0_data", {24'd0, out0_data}, 32'h11);
    in_data = 8'h22;
    #1 chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("stall_hold_data", {24'd0, out0_data}, 32'h11);
    chk("stall_hold_valid", {31'd0, out0_valid}, 32'd1);
    out0_ready = 1'b1;
    #1 chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("stall_follow_data", {24'd0, out0_data}, 32'h22);
    in_sel = 1'b1; in_data = 8'h33;
    cyc();
    chk("stall_out1_data", {24'd0, out1_data}, 32'h33);
    chk("stall_out1_valid", {31'd0, out1_valid}, 32'd1);
    in_valid = 1'b0;
    cyc();

    // Back-to-back into out1
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 1'b1; in_data = 8'(i);
      #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      chk("b2b_out1_valid", {31'd0, out1_valid}, 32'd1);
      chk("b2b_out1_data", {24'd0, out1_data}, i);
    end
    in_valid = 1'b0;
    cyc();

    // Mid-operation reset discards held beats
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
    cyc();
    in_sel = 1'b1; in_data = 8'hAA;
    cyc();
    chk("mid_full0", {31'd0, out0_valid}, 32'd1);
    chk("mid_full1_data", {24'd0, out1_data}, 32'hAA);
    in_valid = 1'b0; rst = 1'b1;
    cyc();
    chk("mid_rst_v0", {31'd0, out0_valid}, 32'd0);
    chk("mid_rst_v1", {31'd0, out1_valid}, 32'd0);
    rst = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    cyc();
    chk("mid_after_v0", {31'd0, out0_valid}, 32'd0);
    chk("mid_after_v1", {31'd0, out1_valid}, 32'd0);

`ifdef DEMUX_CNT_EN
    // Counter wrap: 65536 accepted beats give 65535 drains
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h5A;
    for (int i = 0; i < 65536; i++) cyc();
    chk("cnt_preload", {16'd0, out0_cnt}, 32'h0000FFFF);
    cyc();
    chk("cnt_wrap", {16'd0, out0_cnt}, 32'h00000000);
    chk("cnt_out1_same", {16'd0, out1_cnt}, 32'd0);
    in_valid = 1'b0;
    cyc();
`endif

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
